// File: rtl/npu_seq.sv
// Job sequencer for a 3x3 systolic array: fetches input vectors, skews them onto the
// array rows, deskews the column results and writes one 48-bit result per vector.
module npu_seq #(
    parameter int unsigned AWIDTH = 4,
    parameter int unsigned LAT    = 3
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        len,
    output logic [AWIDTH-1:0] in_rd_addr,
    input  logic [23:0]       in_rd_data,
    output logic              en,
    output logic [7:0]        in1,
    output logic [7:0]        in2,
    output logic [7:0]        in3,
    input  logic [15:0]       o_1,
    input  logic [15:0]       o_2,
    input  logic [15:0]       o_3,
    output logic              out_we,
    output logic [AWIDTH-1:0] out_addr,
    output logic [47:0]       out_wdata,
    output logic              busy,
    output logic              done
);

    // cyc_q counts from 0 in the first FETCH cycle, i.e. cyc_q = issue cycle + 2
    localparam int unsigned CW = $clog2(LAT + 24);

    typedef enum logic [1:0] {StIdle, StFetch, StRun, StFinish} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cyc_q, cyc_d;
    logic [3:0]         len_q, len_d;
    logic [AWIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [7:0]         in1_q, in1_d, in2_q, in2_d, in3_q, in3_d;
    logic [7:0]         b1_q, b1_d, b2a_q, b2a_d, b2b_q, b2b_d;
    logic [15:0]        d1a_q, d1a_d, d1b_q, d1b_d, d2a_q, d2a_d;
    logic               en_q, en_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic [AWIDTH-1:0]  oaddr_q, oaddr_d;
    logic [47:0]        wdata_q, wdata_d;

    logic [CW-1:0]      len_c, cyc_inc, en_last, wr_first, last_c;
    logic               run_ok;

    assign len_c    = CW'(len_q);
    assign cyc_inc  = cyc_q + CW'(1);
    assign en_last  = len_c + CW'(LAT + 2);
    assign wr_first = CW'(LAT + 4);
    assign last_c   = len_c + CW'(LAT + 4);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            cyc_q     <= '0;
            len_q     <= '0;
            rd_addr_q <= '0;
            in1_q     <= '0;
            in2_q     <= '0;
            in3_q     <= '0;
            b1_q      <= '0;
            b2a_q     <= '0;
            b2b_q     <= '0;
            d1a_q     <= '0;
            d1b_q     <= '0;
            d2a_q     <= '0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            oaddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            len_q     <= len_d;
            rd_addr_q <= rd_addr_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            in3_q     <= in3_d;
            b1_q      <= b1_d;
            b2a_q     <= b2a_d;
            b2b_q     <= b2b_d;
            d1a_q     <= d1a_d;
            d1b_q     <= d1b_d;
            d2a_q     <= d2a_d;
            en_q      <= en_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            oaddr_q   <= oaddr_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = (len != 4'd0) ? StFetch : StFinish;
            end
            StFetch: begin
                if (abort)                   state_d = StIdle;
                else if (cyc_q == CW'(1))    state_d = StRun;
            end
            StRun: begin
                if (abort)                   state_d = StIdle;
                else if (cyc_q == last_c)    state_d = StFinish;
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Job continues into the next cycle: neither aborted nor leaving RUN for FINISH
    assign run_ok = (state_q == StFetch || state_q == StRun) &&
                    (state_d == StFetch || state_d == StRun);

    always_comb begin
        cyc_d     = cyc_q;
        len_d     = len_q;
        rd_addr_d = rd_addr_q;
        oaddr_d   = oaddr_q;
        in1_d     = '0;
        in2_d     = '0;
        in3_d     = '0;
        b1_d      = '0;
        b2a_d     = '0;
        b2b_d     = '0;
        d1a_d     = o_1;
        d1b_d     = d1a_q;
        d2a_d     = o_2;
        en_d      = 1'b0;
        we_d      = 1'b0;
        wdata_d   = '0;
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StFinish);

        if (state_q == StIdle && start && len != 4'd0) begin
            len_d     = len;
            cyc_d     = '0;
            rd_addr_d = '0;
        end

        if (run_ok) begin
            cyc_d = cyc_inc;
            if (cyc_inc < len_c) rd_addr_d = AWIDTH'(cyc_inc);
            // Read data for vector cyc_q-1 is on the bus now
            if (cyc_q >= CW'(1) && cyc_q <= len_c) begin
                in1_d = in_rd_data[7:0];
                b1_d  = in_rd_data[15:8];
                b2a_d = in_rd_data[23:16];
            end
            in2_d = b1_q;
            b2b_d = b2a_q;
            in3_d = b2b_q;
            en_d  = (cyc_q >= CW'(1)) && (cyc_q <= en_last);
            if (cyc_q >= wr_first && (cyc_q - wr_first) < len_c) begin
                we_d    = 1'b1;
                oaddr_d = AWIDTH'(cyc_q - wr_first);
                wdata_d = {o_3, d2a_q, d1b_q};
            end
        end
    end

    assign in_rd_addr = rd_addr_q;
    assign en         = en_q;
    assign in1        = in1_q;
    assign in2        = in2_q;
    assign in3        = in3_q;
    assign out_we     = we_q;
    assign out_addr   = oaddr_q;
    assign out_wdata  = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/npu_seq.md
NPU_SEQ -- requirements
Module: npu_seq

Interface
REQ-001 Parameter AWIDTH, default 4: width of the input-buffer and output-buffer address ports.
REQ-002 Parameter LAT, default 3: cycles from issue cycle k (the cycle in1 carries byte 0 of vector k) to the cycle o_1 carries column-1 result of vector k.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports wb_clk_i (clock) and wb_rst_i (reset).
REQ-004 Ports, in this order:
  wb_clk_i  in  1  clock
  wb_rst_i  in  1  synchronous active-high reset
  start  in  1  job request, sampled in IDLE
  abort  in  1  cancel the running job
  len  in  4  number of vectors in the job, 0..15
  in_rd_addr  out  AWIDTH  input-buffer read address
  in_rd_data  in  24  input-buffer read data, valid one cycle after the address; {byte2,byte1,byte0}
  en  out  1  systolic-array enable
  in1, in2, in3  out  8 each  skewed row operands to array rows 1..3
  o_1, o_2, o_3  in  16 each  array column outputs
  out_we  out  1  result write strobe
  out_addr  out  AWIDTH  result write address (vector index)
  out_wdata  out  48  deskewed result {o_3,o_2,o_1}
  busy  out  1  job in progress
  done  out  1  one-cycle completion pulse

Function
REQ-005 FSM states: IDLE, FETCH, RUN, FINISH; every output SHALL be registered.
REQ-006 IDLE with start=1 and len!=0 SHALL latch len and enter FETCH; call that start cycle S. Cycle S+3 is issue cycle 0, and cycle n means S+3+n.
REQ-007 IDLE with start=1 and len=0 SHALL go to FINISH directly, with no reads, no en and no writes.
REQ-008 start SHALL be ignored outside IDLE.
REQ-009 busy SHALL be 1 in every state except IDLE.
REQ-010 in_rd_addr SHALL equal k in cycle k-2, for k=0..len-1; after the last read it SHALL hold len-1.
REQ-011 in1 SHALL carry byte0 of vector k in cycle k; in2 SHALL carry byte1 of vector k in cycle k+1; in3 SHALL carry byte2 of vector k in cycle k+2.
REQ-012 Any in1/in2/in3 slot not occupied by a valid vector SHALL be driven 0.
REQ-013 en SHALL be 1 exactly in cycles 0 .. len-1+LAT+2, and 0 otherwise.
REQ-014 The block SHALL capture o_1 of vector k at the end of cycle k+LAT, o_2 at the end of cycle k+LAT+1, and o_3 at the end of cycle k+LAT+2, using internal delay registers.
REQ-015 In cycle k+LAT+3 the block SHALL drive out_we=1, out_addr=k and out_wdata={o_3,o_2,o_1} of vector k; each vector SHALL be written exactly once, in ascending k.
REQ-016 The FSM SHALL be in FETCH for cycles -2..-1 and in RUN from cycle 0 through the last write cycle, len-1+LAT+3.
REQ-017 FINISH SHALL last one cycle with done=1 and busy=1, then return to IDLE.
REQ-018 Internal cycle counter width SHALL cover len-1+LAT+3 with no wrap-around; len=15 SHALL complete correctly.
REQ-019 abort=1 in any non-IDLE state SHALL take effect on the next cycle:
  - state goes to IDLE;
  - en, out_we, in1..in3 and busy go to 0;
  - done is not pulsed;
  - in-flight results are discarded.
REQ-020 abort in IDLE SHALL be ignored.
REQ-021 When start and abort are both 1 in IDLE, start SHALL win.
REQ-022 Outputs outside the stated windows SHALL be 0, except in_rd_addr and out_addr, which SHALL hold their last value.

Reset
REQ-023 wb_rst_i=1 at a clock edge SHALL force IDLE and clear every output to 0: busy, done, en, out_we, in1..in3, in_rd_addr, out_addr, out_wdata. All delay and skew registers SHALL also clear.
REQ-024 Reset SHALL take priority over start and abort.
REQ-025 Reset asserted mid-job SHALL abandon the job without a done pulse.

Verification
REQ-026 Basic job, len=1, buffer[0]=24'h030201, array model returning o_c = 16'h0100*c + k:
  - in1=01 at cycle 0, in2=02 at cycle 1, in3=03 at cycle 2;
  - en=1 for cycles 0..5;
  - out_we at cycle 6 with out_addr=0 and out_wdata={0300,0200,0100};
  - done at cycle 7.
REQ-027 Full job, len=15, with the same model:
  - 15 writes at cycles 6..20, addresses 0..14, none missing or duplicated;
  - en falls after cycle 19;
  - done at cycle 21;
  - busy is 1 for cycles -2..21.
REQ-028 Zero-length job, start with len=0: done=1 on the next cycle, en and out_we stay 0 throughout, busy is 1 for one cycle.
REQ-029 Abort, len=8, abort asserted at cycle 4:
  - from cycle 5, en=0, out_we=0 and busy=0, with no done;
  - a following start with len=2 runs normally.
REQ-030 start pulses during RUN are ignored, with no change to the write sequence.
REQ-031 Reset asserted at cycle 3 of a len=4 job clears all outputs on the next cycle, with no done; start and reset asserted together leave the block in IDLE.
